// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: decode inputs and datapath control outputs of the multicycle controller.
// The master side (datapath) drives op/Zero/mem_ready; the slave side (controller) drives the controls.
interface multicycle_controller_if;
    logic [6:0] op;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       illegal;
    modport master (
        output op, Zero, mem_ready,
        input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
    );
    modport slave (
        input  op, Zero, mem_ready,
        output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RISC-V style datapath,
// with memory wait states and an absorbing trap for unsupported opcodes.
module multicycle_controller (
    input logic                  clk,
    input logic                  reset_n,
    multicycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state, next;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= FETCH;
        else          state <= next;

    always_comb begin
        next = state;
        case (state)
            FETCH:    next = bus.mem_ready ? DECODE : FETCH;
            DECODE:   next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                             (bus.op == OP_R)   ? EXECUTER :
                             (bus.op == OP_I)   ? EXECUTEI :
                             (bus.op == OP_BEQ) ? BEQ :
                             (bus.op == OP_JAL) ? JAL : TRAP;
            MEMADR:   next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next = bus.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next = bus.mem_ready ? FETCH : MEMWRITE;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            JAL:      next = ALUWB;
            MEMWB:    next = FETCH;
            ALUWB:    next = FETCH;
            BEQ:      next = FETCH;
            TRAP:     next = TRAP;
            default:  next = FETCH;
        endcase
    end

    assign bus.ImmSrc = (bus.op == OP_SW)  ? 2'b01 :
                        (bus.op == OP_BEQ) ? 2'b10 :
                        (bus.op == OP_JAL) ? 2'b11 : 2'b00;

    // Reset forces FETCH, so gating the fetch strobes with reset_n keeps them low during reset.
    always_comb begin
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = 2'b00;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ALUOp     = 2'b00;
        bus.illegal   = 1'b0;
        case (state)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready & reset_n;
                bus.PCWrite   = bus.mem_ready & reset_n;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXECUTER: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b10;
            end
            EXECUTEI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = 2'b10;
            end
            ALUWB:    bus.RegWrite = 1'b1;
            BEQ: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUOp   = 2'b01;
                bus.PCWrite = bus.Zero;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
            end
            TRAP:     bus.illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scenarios plus random instruction streams, checked every cycle
// against a model that walks each instruction's list of steps.
module tb_multicycle_controller;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, IL = 7'b1110011;

    logic clk = 1'b0;
    logic reset_n;
    int   n_err = 0;
    int   n_chk = 0;
    int   path = 0;
    int   pos = 0;
    logic [6:0] ops [6];

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    logic [15:0] dv;
    assign dv = {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite, bus.ResultSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};

    // Each instruction is a string of step letters; F, R and M are memory steps that wait on mem_ready.
    function automatic byte step_at(int p, int i);
        string t;
        case (p)
            1: t = "FDARW";
            2: t = "FDAM";
            3: t = "FDXB";
            4: t = "FDYB";
            5: t = "FDQ";
            6: t = "FDJB";
            7: t = "FDT";
            default: t = "FD";
        endcase
        return t.getc(i);
    endfunction

    function automatic int path_len(int p);
        return (p == 1) ? 5 : (p == 5 || p == 7) ? 3 : (p == 0) ? 2 : 4;
    endfunction

    function automatic int path_of(logic [6:0] o);
        return (o == LW) ? 1 : (o == SW) ? 2 : (o == RT) ? 3 : (o == IT) ? 4 :
               (o == BQ) ? 5 : (o == JL) ? 6 : 7;
    endfunction

    function automatic logic [15:0] expv(byte c, logic rn, logic mr, logic z, logic [6:0] o);
        logic pw, iw, as, mw, rw, il;
        logic [1:0] rs, sa, sb, ao, im;
        {pw, iw, as, mw, rw, il} = '0;
        {rs, sa, sb, ao} = '0;
        im = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        case (c)
            "F": begin pw = mr & rn; iw = mr & rn; rs = 2'b10; sb = 2'b10; end
            "D": begin sa = 2'b01; sb = 2'b01; end
            "A": begin sa = 2'b10; sb = 2'b01; end
            "R": as = 1'b1;
            "W": begin rs = 2'b01; rw = 1'b1; end
            "M": begin as = 1'b1; mw = 1'b1; end
            "X": begin sa = 2'b10; ao = 2'b10; end
            "Y": begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            "B": rw = 1'b1;
            "Q": begin sa = 2'b10; ao = 2'b01; pw = z; end
            "J": begin sa = 2'b01; sb = 2'b10; pw = 1'b1; end
            "T": il = 1'b1;
            default: ;
        endcase
        return {pw, iw, as, mw, rw, rs, sa, sb, ao, im, il};
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        byte c;
        int np, ns;
        np = path;
        ns = pos;
        if (!reset_n) begin
            np = 0;
            ns = 0;
        end else begin
            c = step_at(path, pos);
            if (c == "T" || ((c == "F" || c == "R" || c == "M") && !bus.mem_ready)) ;
            else if (c == "D") begin np = path_of(bus.op); ns = 2; end
            else if (c == "A") begin np = (bus.op == LW) ? 1 : 2; ns = 3; end
            else if (pos + 1 >= path_len(path)) begin np = 0; ns = 0; end
            else ns = pos + 1;
        end
        path <= np;
        pos  <= ns;
    end

    always @(negedge clk)
        chk("cycle", dv, expv(step_at(path, pos), reset_n, bus.mem_ready, bus.Zero, bus.op));

    task automatic drive(logic [6:0] o, logic z, logic mr);
        @(posedge clk);
        #1;
        bus.op = o;
        bus.Zero = z;
        bus.mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic rel(logic [6:0] o, logic z, logic mr);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.op = o;
        bus.Zero = z;
        bus.mem_ready = mr;
        @(negedge clk);
    endtask

    function automatic logic [6:0] rand_op();
        return ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 5)] : 7'($urandom);
    endfunction

    initial begin
        int rwc, rwk, rsk, mwc, ilc;
        logic [6:0] mwp;
        logic [2:0] pwp;
        logic [7:0] fw;
        ops = '{LW, SW, RT, IT, BQ, JL};
        reset_n = 1'b0;
        bus.op = 7'd0;
        bus.Zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_outputs", dv, 16'h0440);

        rel(LW, 0, 1);
        chk("lw_fetch_strobes", {14'd0, dv[15:14]}, 16'h0003);
        rwc = 0; rwk = 0; rsk = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) drive(LW, 0, 1);
            if (dv[11]) begin rwc++; rwk = k; end
            if (dv[10:9] == 2'b01) rsk = rsk * 8 + k;
        end
        chk("lw_regwrite_cycle", 16'({rwc[3:0], rwk[3:0], rsk[3:0]}), 16'h155);

        mwp = '0; mwc = 0;
        for (int k = 0; k < 7; k++) begin
            drive(SW, 0, (k >= 3 && k <= 5) ? 1'b0 : 1'b1);
            if (k == 0) chk("sw_fetch_irwrite", {15'd0, dv[14]}, 16'd1);
            if (k == 1) chk("sw_immsrc", {14'd0, dv[2:1]}, 16'd1);
            mwp = {mwp[5:0], dv[12]};
            mwc += dv[11];
        end
        chk("sw_memwrite_pattern", {9'd0, mwp}, 16'h000F);
        chk("sw_no_regwrite", 16'(mwc), 16'd0);

        pwp = '0;
        for (int k = 0; k < 3; k++) begin drive(BQ, 1, 1); pwp = {pwp[1:0], dv[15]}; end
        chk("beq_taken_pcwrite", {13'd0, pwp}, 16'h0005);
        pwp = '0;
        for (int k = 0; k < 3; k++) begin drive(BQ, 0, 1); pwp = {pwp[1:0], dv[15]}; end
        chk("beq_not_taken_pcwrite", {13'd0, pwp}, 16'h0004);

        fw = '0;
        for (int k = 0; k < 4; k++) begin drive(RT, 0, (k >= 2) ? 1'b1 : 1'b0); fw = {fw[5:0], dv[14], dv[15]}; end
        chk("fetch_wait_strobes", {8'd0, fw}, 16'h000C);
        drive(RT, 0, 1);
        drive(RT, 0, 1);

        drive(IL, 0, 1);
        drive(IL, 0, 1);
        chk("trap_decode_no_illegal", {15'd0, dv[0]}, 16'd0);
        ilc = 0;
        for (int k = 0; k < 10; k++) begin drive(7'($urandom), 1'($urandom), 1'($urandom)); ilc += dv[0]; end
        chk("trap_illegal_held", 16'(ilc), 16'd10);
        bus.mem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("trap_async_reset", {14'd0, dv[15], dv[0]}, 16'd0);

        rel(RT, 0, 1);
        drive(RT, 0, 1);
        drive(RT, 0, 1);
        drive(RT, 0, 1);
        chk("aluwb_regwrite", {15'd0, dv[11]}, 16'd1);
        reset_n = 1'b0;
        #1;
        chk("aluwb_async_reset", dv, 16'h0440);
        bus.mem_ready = 1'b0;

        rel(JL, 0, 1);
        chk("after_reset_fetch", {14'd0, dv[15:14]}, 16'h0003);
        drive(JL, 0, 1);
        chk("jal_immsrc", {14'd0, dv[2:1]}, 16'd3);
        drive(JL, 0, 1);
        chk("jal_pcwrite", {15'd0, dv[15]}, 16'd1);
        drive(JL, 0, 1);
        chk("jal_regwrite", {15'd0, dv[11]}, 16'd1);

        for (int k = 0; k < 800; k++) begin
            if ((step_at(path, pos) == "T" && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
                reset_n = 1'b0;
                #1;
                chk("rand_async_reset", {11'd0, dv[15:11]}, 16'd0);
                rel(rand_op(), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            end else
                drive(rand_op(), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  7  opcode of the instruction register, instr[6:0].
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current access in this cycle.
REQ-007 PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc  output  2 each  datapath selects.
REQ-009 illegal  output  1  unsupported opcode trapped.

Function
REQ-010 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL and TRAP.
REQ-011 Every output not listed for a state SHALL be 0 in that state, except ImmSrc.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=1 and PCWrite=1 only when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
- TRAP: illegal=1.
REQ-012 ImmSrc SHALL be decoded combinationally from op in all states:
- 0000011 and 0010011 -> 00.
- 0100011 -> 01.
- 1100011 -> 10.
- 1101111 -> 11.
- any other op -> 00.
REQ-013 FETCH SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-014 DECODE SHALL branch on op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other op -> TRAP.
REQ-015 MEMADR SHALL go to MEMREAD when op=0000011 and to MEMWRITE otherwise.
REQ-016 MEMREAD SHALL hold while mem_ready=0 and go to MEMWB when mem_ready=1.
REQ-017 MEMWRITE SHALL hold while mem_ready=0 and go to FETCH when mem_ready=1.
REQ-018 EXECUTER and EXECUTEI SHALL go to ALUWB.
REQ-019 MEMWB, ALUWB and BEQ SHALL go to FETCH.
REQ-020 JAL SHALL go to ALUWB.
REQ-021 TRAP SHALL be absorbing; only reset leaves it.
REQ-022 Cycles per instruction with mem_ready held at 1:
- lw 5; sw 4; R-type 4; I-type ALU 4; beq 3; jal 4.
- Each mem_ready=0 cycle in a waiting state SHALL add exactly one cycle.
REQ-023 A change of op outside DECODE and MEMADR SHALL NOT affect state transitions.
REQ-024 PCWrite SHALL assert for at most one cycle per instruction in FETCH, BEQ and JAL.

Reset
REQ-025 While reset_n=0 the state SHALL be FETCH immediately, independent of clk.
REQ-026 While reset_n=0 IRWrite, PCWrite, MemWrite, RegWrite and illegal SHALL be 0.
REQ-027 While reset_n=0 the remaining outputs SHALL take their FETCH values.
REQ-028 Reset asserted mid-instruction, including in a wait state or TRAP, SHALL abort the instruction with no further RegWrite or MemWrite pulse.
REQ-029 After reset_n rises, the first active edge SHALL evaluate FETCH.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- lw (op=0000011), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5.
- sw, mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; RegWrite never 1.
- beq: Zero=1 -> PCWrite=1 in cycle 3; Zero=0 -> PCWrite=0 throughout; both return to FETCH after 3 cycles.
- FETCH with mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 for those cycles, then a single-cycle pulse of both.
- op=1110011 -> TRAP after DECODE; illegal=1 held for 10 cycles; reset_n low -> illegal=0 without a clock edge.
- reset_n pulsed low in ALUWB of an R-type -> outputs at reset values asynchronously; next instruction starts in FETCH.
